multicycle_control_unit: RTL

//  Multi-cycle RV32I main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/multicycle_control_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath selects.
// Latency: 3-5 cycles per instruction with zero-wait memory; FETCH and MEM stall on mem_ready.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit ENABLE_IMM  = 1'b1,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       trap_clr,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // With no timeout the counter simply wraps; it is never compared.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WLAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [6:0]    op_q;
  logic [CW-1:0] wcnt;
  logic [2:0]    state_nxt;
  logic          legal_op;
  logic          in_wait;
  logic          timeout;

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_R, OP_LOAD, OP_STORE, OP_BRANCH: legal_op = 1'b1;
      OP_IMM:                             legal_op = ENABLE_IMM;
      OP_JAL:                             legal_op = ENABLE_JAL;
      default:                            legal_op = 1'b0;
    endcase
  end

  assign in_wait = (state == S_FETCH) || (state == S_MEM);
  // A ready arriving on the last allowed cycle completes the access instead of trapping.
  assign timeout = (MEM_TIMEOUT > 0) && in_wait && !mem_ready && (wcnt == WLAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_TRAP;
      S_DECODE: state_nxt = legal_op ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          OP_BRANCH:         state_nxt = S_FETCH;
          default:           state_nxt = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) state_nxt = (op_q == OP_LOAD) ? S_WB : S_FETCH;
                else if (timeout) state_nxt = S_TRAP;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   if (trap_clr) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      wcnt    <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= opcode;
      if (state_nxt != state) wcnt <= '0;
      else if (in_wait && !mem_ready) wcnt <= wcnt + 1'b1;
      if (state == S_DECODE && !legal_op) illegal <= 1'b1;
      if (timeout) bus_err <= 1'b1;
      if (state == S_TRAP && trap_clr) begin
        illegal <= 1'b0;
        bus_err <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b10;
      S_EXEC: begin
        case (op_q)
          OP_R:      begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
          OP_IMM:    begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b10; end
          OP_LOAD,
          OP_STORE:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
          OP_BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; Branch = 1'b1; end
          OP_JAL:    PCWrite = 1'b1;
          default:   ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemRead  = (op_q == OP_LOAD);
        MemWrite = (op_q == OP_STORE);
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (op_q == OP_LOAD)     MemtoReg = 2'b01;
        else if (op_q == OP_JAL) MemtoReg = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
